// File: rtl/prbs_range_gen.sv
// Pseudo-random generator for game placement: a free-running maximal-length LFSR with periodic
// reseeding, plus a request/valid port that returns samples bounded by rejection sampling.
module prbs_range_gen #(
    parameter int WIDTH         = 7,
    parameter int RESEED_PERIOD = 1024,
    parameter int TIMEOUT       = 2 ** WIDTH
) (
    input  logic             clock_25,
    input  logic             reset,
    input  logic [WIDTH-1:0] initial_seed,
    input  logic [WIDTH-1:0] max_value,
    input  logic             req,
    output logic [WIDTH-1:0] rnd,
    output logic             busy,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    output logic             timeout
);

    // Feedback taps for a maximal-length sequence at each supported width
    function automatic logic [15:0] tap_mask(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    localparam logic [15:0]      TAPS16 = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS   = TAPS16[WIDTH-1:0];
    localparam int               RCW    = $clog2(RESEED_PERIOD);
    localparam int               SCW    = $clog2(TIMEOUT + 1);
    localparam logic [RCW-1:0]   RESEED_LAST = RCW'(RESEED_PERIOD - 1);
    localparam logic [SCW-1:0]   SEARCH_LAST = SCW'(TIMEOUT - 1);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] seed;
    logic [RCW-1:0]   reseed_cnt;
    logic [WIDTH-1:0] bound;
    logic [SCW-1:0]   search_cnt;

    logic             fb;
    logic [WIDTH-1:0] seed_plus;
    logic [WIDTH-1:0] lfsr_init;
    logic [WIDTH-1:0] seed_init;
    logic [WIDTH-1:0] seed_next;

    // Zero is the LFSR lock-up state, so every seed path steers around it
    assign fb        = ^(lfsr & TAPS);
    assign seed_plus = initial_seed + WIDTH'(1);
    assign lfsr_init = (initial_seed == '0) ? WIDTH'(1) : initial_seed;
    assign seed_init = (seed_plus == '0) ? WIDTH'(1) : seed_plus;
    assign seed_next = (seed == '1) ? WIDTH'(1) : seed + WIDTH'(1);
    assign rnd       = lfsr;

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            lfsr       <= lfsr_init;
            seed       <= seed_init;
            reseed_cnt <= '0;
        end else if (reseed_cnt == RESEED_LAST) begin
            lfsr       <= seed;
            seed       <= seed_next;
            reseed_cnt <= '0;
        end else begin
            lfsr       <= {lfsr[WIDTH-2:0], fb};
            reseed_cnt <= reseed_cnt + RCW'(1);
        end
    end

    // The bound is captured at acceptance so the consumer may change max_value mid-search
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bound        <= '0;
            search_cnt   <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            timeout      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        bound      <= max_value;
                        search_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (lfsr <= bound) begin
                        sample       <= lfsr;
                        sample_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (search_cnt == SEARCH_LAST) begin
                        sample       <= bound;
                        sample_valid <= 1'b1;
                        timeout      <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        search_cnt <= search_cnt + SCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_range_gen.sv
// Bench for prbs_range_gen: fixed vector tables, a reseed instance, and randomized bounded
// requests checked against a cycle-indexed model of the expected random stream.
module tb_prbs_range_gen;

    localparam int W    = 7;
    localparam int PA   = 1024;
    localparam int PB   = 4;
    localparam int TO   = 128;
    localparam int MAXN = 40000;

    logic         clock_25 = 1'b0;
    logic         reset_a, reset_b;
    logic [W-1:0] seed_a, seed_b, max_a, max_b;
    logic         req_a, req_b;
    logic [W-1:0] rnd_a, sample_a, rnd_b, sample_b;
    logic         busy_a, valid_a, timeout_a, busy_b, valid_b, timeout_b;

    int errors = 0;
    int checks = 0;
    int n      = 0;
    int last_sample = 0;
    int exp_rnd [MAXN];

    typedef struct {
        int     edge_no;
        bit     on_b;
        int     rnd;
    } vec_t;

    always #20 clock_25 = ~clock_25;

    prbs_range_gen #(.WIDTH(W), .RESEED_PERIOD(PA), .TIMEOUT(TO)) dut_a (
        .clock_25(clock_25), .reset(reset_a), .initial_seed(seed_a), .max_value(max_a),
        .req(req_a), .rnd(rnd_a), .busy(busy_a), .sample(sample_a),
        .sample_valid(valid_a), .timeout(timeout_a)
    );

    prbs_range_gen #(.WIDTH(W), .RESEED_PERIOD(PB), .TIMEOUT(TO)) dut_b (
        .clock_25(clock_25), .reset(reset_b), .initial_seed(seed_b), .max_value(max_b),
        .req(req_b), .rnd(rnd_b), .busy(busy_b), .sample(sample_b),
        .sample_valid(valid_b), .timeout(timeout_b)
    );

    // x^7 + x^6 + 1 stepped with plain integer arithmetic
    function automatic int lfsr_next(input int v);
        return ((v << 1) | (((v >> 6) ^ (v >> 5)) & 1)) & 127;
    endfunction

    // exp_rnd[e] is the expected rnd after e clock edges since reset release
    task automatic build_model(input int s);
        int sd;
        exp_rnd[0] = (s == 0) ? 1 : s;
        sd = (s + 1) % 128;
        if (sd == 0) sd = 1;
        for (int t = 0; t < MAXN - 1; t++) begin
            if (t % PA == PA - 1) begin
                exp_rnd[t + 1] = sd;
                sd = (sd == 127) ? 1 : sd + 1;
            end else begin
                exp_rnd[t + 1] = lfsr_next(exp_rnd[t]);
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_25);
        n++;
        @(negedge clock_25);
    endtask

    task automatic reset_a_with(input int s);
        reset_a = 1'b0;
        req_a   = 1'b0;
        seed_a  = W'(s);
        @(posedge clock_25);
        @(negedge clock_25);
        reset_a = 1'b1;
        n = 0;
        last_sample = 0;
        build_model(s);
    endtask

    task automatic run_idle(input int cycles);
        req_a = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            checkOutput("rnd_stream", rnd_a, exp_rnd[n]);
            checkOutput("rnd_nonzero", (rnd_a != 0), 1);
        end
    endtask

    // Issues one request, predicts hit/timeout from the model stream, and checks each cycle
    task automatic applyStimulus(input int mx, input bit hold);
        int a, hit, lat, exp_s;
        bit to;
        if (n + TO + 4 >= MAXN) begin
            errors++;
            $display("[TB] FAIL model_range: edge %0d exceeds model depth %0d", n, MAXN);
            return;
        end
        req_a = 1'b1;
        max_a = W'(mx);
        tick();
        a = n;
        if (!hold) req_a = 1'b0;
        max_a = W'($urandom_range(0, 127));
        checkOutput("accept_busy_valid", {busy_a, valid_a}, 2'b10);
        checkOutput("sample_held", sample_a, last_sample);
        hit = -1;
        for (int k = 0; k < TO; k++) begin
            if (exp_rnd[a + k] <= mx) begin
                hit = k;
                break;
            end
        end
        lat   = (hit >= 0) ? hit + 1 : TO;
        exp_s = (hit >= 0) ? exp_rnd[a + hit] : mx;
        to    = (hit < 0);
        for (int c = 1; c < lat; c++) begin
            tick();
            checkOutput("search_busy_valid", {busy_a, valid_a}, 2'b10);
        end
        tick();
        checkOutput("done_busy_valid_to", {busy_a, valid_a, timeout_a}, {1'b0, 1'b1, to});
        checkOutput("sample", sample_a, exp_s);
        checkOutput("rnd_at_done", rnd_a, exp_rnd[n]);
        last_sample = exp_s;
    endtask

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[$];
        reset_a = 1'b0; reset_b = 1'b0;
        seed_a = '0; seed_b = '0; max_a = '0; max_b = '0;
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clock_25);

        // Sequence from seed 01 on instance A, reseed walk from 7E on instance B
        vecs = '{'{0, 0, 'h01}, '{0, 1, 'h7E}, '{1, 0, 'h02}, '{1, 1, 'h7C},
                 '{2, 0, 'h04}, '{2, 1, 'h78}, '{3, 0, 'h08}, '{3, 1, 'h70},
                 '{4, 0, 'h10}, '{4, 1, 'h7F}, '{5, 0, 'h20}, '{5, 1, 'h7E},
                 '{6, 0, 'h41}, '{7, 0, 'h03}, '{8, 1, 'h01}, '{9, 1, 'h02},
                 '{126, 0, 'h40}, '{127, 0, 'h01}};
        seed_b = 7'h7E;
        reset_a_with(1);
        reset_b = 1'b1;
        checkOutput("reset_outputs", {busy_a, valid_a, timeout_a, sample_a}, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            while (n < vecs[i].edge_no) tick();
            checkOutput(vecs[i].on_b ? "rnd_b_vec" : "rnd_a_vec",
                        vecs[i].on_b ? rnd_b : rnd_a, vecs[i].rnd);
        end
        run_idle(100);

        // Zero seed must be steered to 1 and never produce a zero state
        reset_a_with(0);
        checkOutput("zero_seed_rnd", rnd_a, 1);
        run_idle(2000);

        // Full-range bound, back-to-back held requests, then randomized requests
        reset_a_with($urandom_range(0, 127));
        checkOutput("reset_outputs2", {busy_a, valid_a, timeout_a, sample_a}, 0);
        for (int i = 0; i < 3; i++) applyStimulus(127, 1'b0);
        for (int i = 0; i < 200; i++) applyStimulus(10, 1'b1);
        req_a = 1'b0;
        run_idle(3);
        reset_a_with($urandom_range(0, 127));
        for (int i = 0; i < 40; i++) begin
            applyStimulus($urandom_range(1, 127), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) run_idle($urandom_range(0, 5));
        end

        // Empty range forces the fallback; then reset lands mid-search
        reset_a_with($urandom_range(0, 127));
        applyStimulus(0, 1'b0);
        req_a = 1'b1;
        max_a = '0;
        tick();
        req_a = 1'b0;
        repeat (20) tick();
        checkOutput("midsearch_busy", {busy_a, valid_a}, 2'b10);
        #5;
        reset_a = 1'b0;
        #1;
        checkOutput("reset_mid_busy_valid", {busy_a, valid_a, timeout_a}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_25);
            checkOutput("reset_hold_valid", {busy_a, valid_a}, 0);
        end
        reset_a_with(5);
        run_idle(TO + 4);
        checkOutput("no_stale_valid", {busy_a, valid_a, sample_a}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
